conv_ctrl: RTL and testbench

Sequencer for the 25-tap convolution tree in the renkon core. For every (output channel, input channel) pair it loads a 5x5 kernel into the tree's weight registers, streams the input feature map through the line buffer, and tags each valid window. Those tags are delayed by the tree's fixed pipeline latency, so the downstream accumulator receives `valid`, `first`, `last` and the output coordinate aligned with the tree's `fmap` output. The block sits between the layer-level controller (`req`/`ack`) and the datapath (line buffer, weight RAM, `conv_tree25`, accumulator).

---
 rtl/conv_ctrl_if.sv | 40 ++++
 rtl/conv_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_conv_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_if.sv
// Handshake and datapath-control bundle between the layer controller and conv_ctrl.
// Latency: none, wires only.
// Backpressure: none; req is a start pulse and ack is a completion pulse.
interface conv_ctrl_if #(
    parameter int LWIDTH = 10
);
    // layer controller -> sequencer
    logic              req;
    logic [LWIDTH-1:0] img_size;
    logic [LWIDTH-1:0] in_ch;
    logic [LWIDTH-1:0] out_ch;
    // sequencer -> layer controller
    logic              ack;
    logic              busy;
    // sequencer -> datapath (weight regs, line buffer, RAM addressing)
    logic              w_we;
    logic [4:0]        w_addr;
    logic              b_we;
    logic              pix_en;
    logic [LWIDTH-1:0] mem_ich;
    logic [LWIDTH-1:0] mem_och;
    // sequencer -> accumulator, aligned with the tree output
    logic              out_valid;
    logic              out_first;
    logic              out_last;
    logic [LWIDTH-1:0] out_row;
    logic [LWIDTH-1:0] out_col;

    modport master (
        output req, img_size, in_ch, out_ch,
        input  ack, busy, w_we, w_addr, b_we, pix_en, mem_ich, mem_och,
        input  out_valid, out_first, out_last, out_row, out_col
    );

    modport slave (
        input  req, img_size, in_ch, out_ch,
        output ack, busy, w_we, w_addr, b_we, pix_en, mem_ich, mem_och,
        output out_valid, out_first, out_last, out_row, out_col
    );
endinterface

// File: rtl/conv_ctrl.sv
// Sequencer for the 25-tap conv tree: weight load, fmap stream and tag delay per (och, ich) pair.
// Latency: first w_we the cycle after req is taken; tags reach out_* TREE_LAT cycles after the window.
// Backpressure: none; req is ignored while busy. Optional bias load is enabled by CONV_CTRL_BIAS_EN.
module conv_ctrl #(
    parameter int LWIDTH   = 10,
    parameter int FSIZE    = 5,
    parameter int TREE_LAT = 5
) (
    input  logic        clk,
    input  logic        xrst,
    conv_ctrl_if.slave  bus
);

    localparam int NTAP    = FSIZE * FSIZE;
    localparam int CNT_MAX = (NTAP > TREE_LAT) ? NTAP : TREE_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WEIGHT,
        S_STREAM,
        S_FLUSH,
`ifdef CONV_CTRL_BIAS_EN
        S_DONE,
        S_BIAS
`else
        S_DONE
`endif
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              first;
        logic              last;
        logic [LWIDTH-1:0] row;
        logic [LWIDTH-1:0] col;
    } tag_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [LWIDTH-1:0] img_l, in_ch_l, out_ch_l;
    logic [LWIDTH-1:0] ich, och;
    logic [LWIDTH-1:0] in_row, in_col;
    logic              degenerate;
    logic              last_pix;
    logic              last_ich;
    logic              last_och;
    tag_t              tag_in;
    tag_t              dly [TREE_LAT];

    // Degenerate layers skip straight to DONE; decided on the live inputs at the accepting edge
    assign degenerate = (bus.img_size < LWIDTH'(FSIZE)) || (bus.in_ch == '0) || (bus.out_ch == '0);
    assign last_pix   = (in_row == img_l - LWIDTH'(1)) && (in_col == img_l - LWIDTH'(1));
    assign last_ich   = (ich == in_ch_l - LWIDTH'(1));
    assign last_och   = (och == out_ch_l - LWIDTH'(1));

    // State register
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.req) state_nxt = degenerate ? S_DONE : S_WEIGHT;
            S_WEIGHT: if (cnt == CW'(NTAP - 1)) begin
`ifdef CONV_CTRL_BIAS_EN
                          state_nxt = (ich == '0) ? S_BIAS : S_STREAM;
`else
                          state_nxt = S_STREAM;
`endif
                      end
`ifdef CONV_CTRL_BIAS_EN
            S_BIAS:   state_nxt = S_STREAM;
`endif
            S_STREAM: if (last_pix) state_nxt = last_ich ? S_FLUSH : S_WEIGHT;
            S_FLUSH:  if (cnt == CW'(TREE_LAT - 1)) state_nxt = last_och ? S_DONE : S_WEIGHT;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Size latches, tap/flush counter, pixel position and channel indices
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            img_l    <= '0;
            in_ch_l  <= '0;
            out_ch_l <= '0;
            cnt      <= '0;
            in_row   <= '0;
            in_col   <= '0;
            ich      <= '0;
            och      <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.req) begin
                    img_l    <= bus.img_size;
                    in_ch_l  <= bus.in_ch;
                    out_ch_l <= bus.out_ch;
                    cnt      <= '0;
                    in_row   <= '0;
                    in_col   <= '0;
                    ich      <= '0;
                    och      <= '0;
                end
                S_WEIGHT: cnt <= (cnt == CW'(NTAP - 1)) ? '0 : cnt + CW'(1);
                S_STREAM: begin
                    if (last_pix) begin
                        in_row <= '0;
                        in_col <= '0;
                        if (!last_ich) ich <= ich + LWIDTH'(1);
                    end else if (in_col == img_l - LWIDTH'(1)) begin
                        in_col <= '0;
                        in_row <= in_row + LWIDTH'(1);
                    end else begin
                        in_col <= in_col + LWIDTH'(1);
                    end
                end
                S_FLUSH: begin
                    if (cnt == CW'(TREE_LAT - 1)) begin
                        cnt <= '0;
                        if (!last_och) begin
                            och <= och + LWIDTH'(1);
                            ich <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    ich <= '0;
                    och <= '0;
                end
                default: ;
            endcase
        end
    end

    // Window tag for the pixel currently entering the tree; zero outside STREAM
    always_comb begin
        tag_in = '0;
        if (state == S_STREAM && in_row >= LWIDTH'(FSIZE - 1) && in_col >= LWIDTH'(FSIZE - 1)) begin
            tag_in.valid = 1'b1;
            tag_in.first = (ich == '0);
            tag_in.last  = last_ich;
            tag_in.row   = in_row - LWIDTH'(FSIZE - 1);
            tag_in.col   = in_col - LWIDTH'(FSIZE - 1);
        end
    end

    // Tag delay line matching the tree pipeline; shifts every cycle so tags drain during WEIGHT
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int k = 0; k < TREE_LAT; k++) dly[k] <= '0;
        end else begin
            dly[0] <= tag_in;
            for (int k = 1; k < TREE_LAT; k++) dly[k] <= dly[k-1];
        end
    end

    // Moore outputs decoded from state and counters
    always_comb begin
        bus.busy      = (state != S_IDLE);
        bus.ack       = (state == S_DONE);
        bus.w_we      = (state == S_WEIGHT);
        bus.w_addr    = (state == S_WEIGHT) ? 5'(cnt) : 5'd0;
        bus.pix_en    = (state == S_STREAM);
`ifdef CONV_CTRL_BIAS_EN
        bus.b_we      = (state == S_BIAS);
`else
        bus.b_we      = 1'b0;
`endif
        bus.mem_ich   = ich;
        bus.mem_och   = och;
        bus.out_valid = dly[TREE_LAT-1].valid;
        bus.out_first = dly[TREE_LAT-1].first;
        bus.out_last  = dly[TREE_LAT-1].last;
        bus.out_row   = dly[TREE_LAT-1].row;
        bus.out_col   = dly[TREE_LAT-1].col;
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Self-checking bench for conv_ctrl: per-cycle comparison against an expanded timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_ctrl;

    localparam int LW  = 10;
    localparam int LAT = 5;
`ifdef CONV_CTRL_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif

    typedef struct {
        logic          busy, w_we, b_we, pix_en, ack, ov, of, ol;
        logic [4:0]    w_addr;
        logic [LW-1:0] mich, moch, orow, ocol;
    } exp_t;

    logic clk = 1'b0;
    logic xrst = 1'b0;
    always #5 clk = ~clk;

    conv_ctrl_if #(.LWIDTH(LW)) bus ();

    conv_ctrl #(.LWIDTH(LW), .FSIZE(5), .TREE_LAT(LAT)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_we, n_pix, n_ov, n_busy, n_ack, n_bwe;
    logic got_ov;
    logic [LW-1:0] fo_row, fo_col;
    logic fo_first, fo_last;

    function automatic exp_t zero_e();
        exp_t e;
        e.busy = 0; e.w_we = 0; e.b_we = 0; e.pix_en = 0; e.ack = 0;
        e.ov = 0; e.of = 0; e.ol = 0; e.w_addr = '0;
        e.mich = '0; e.moch = '0; e.orow = '0; e.ocol = '0;
        return e;
    endfunction

    function automatic logic [52:0] pack_e(exp_t e);
        return {e.busy, e.w_we, e.w_addr, e.b_we, e.pix_en, e.ack, e.mich, e.moch,
                e.ov, e.of, e.ol, e.orow, e.ocol};
    endfunction

    function automatic logic [52:0] pack_act();
        return {bus.busy, bus.w_we, bus.w_addr, bus.b_we, bus.pix_en, bus.ack, bus.mem_ich, bus.mem_och,
                bus.out_valid, bus.out_first, bus.out_last, bus.out_row, bus.out_col};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expand one layer into the cycle-by-cycle output timeline it must produce
    task automatic build(input int img, input int ic, input int oc);
        exp_t run[$];
        exp_t e;
        int   tidx[$], trow[$], tcol[$], tfirst[$], tlast[$];
        if (img < 5 || ic == 0 || oc == 0) begin
            e = zero_e(); e.busy = 1; e.ack = 1;
            q.push_back(e);
            return;
        end
        for (int o = 0; o < oc; o++) begin
            for (int i = 0; i < ic; i++) begin
                for (int a = 0; a < 25; a++) begin
                    e = zero_e(); e.busy = 1; e.w_we = 1; e.w_addr = 5'(a);
                    e.mich = LW'(i); e.moch = LW'(o);
                    run.push_back(e);
                end
                if (BIAS == 1 && i == 0) begin
                    e = zero_e(); e.busy = 1; e.b_we = 1; e.mich = LW'(i); e.moch = LW'(o);
                    run.push_back(e);
                end
                for (int p = 0; p < img * img; p++) begin
                    e = zero_e(); e.busy = 1; e.pix_en = 1; e.mich = LW'(i); e.moch = LW'(o);
                    run.push_back(e);
                    if (p / img >= 4 && p % img >= 4) begin
                        tidx.push_back(run.size() - 1 + LAT);
                        trow.push_back(p / img - 4);
                        tcol.push_back(p % img - 4);
                        tfirst.push_back(i == 0);
                        tlast.push_back(i == ic - 1);
                    end
                end
            end
            for (int f = 0; f < LAT; f++) begin
                e = zero_e(); e.busy = 1; e.mich = LW'(ic - 1); e.moch = LW'(o);
                run.push_back(e);
            end
        end
        e = zero_e(); e.busy = 1; e.ack = 1; e.mich = LW'(ic - 1); e.moch = LW'(oc - 1);
        run.push_back(e);
        for (int k = 0; k < tidx.size(); k++) begin
            run[tidx[k]].ov   = 1'b1;
            run[tidx[k]].of   = 1'(tfirst[k]);
            run[tidx[k]].ol   = 1'(tlast[k]);
            run[tidx[k]].orow = LW'(trow[k]);
            run[tidx[k]].ocol = LW'(tcol[k]);
        end
        foreach (run[k]) q.push_back(run[k]);
    endtask

    // Compare every cycle against the model; an empty model means idle (all zero)
    always @(negedge clk) begin
        exp_t e;
        logic [52:0] a, x;
        if (q.size() > 0) e = q.pop_front();
        else              e = zero_e();
        a = pack_act();
        x = pack_e(e);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, a, x);
        end
        if (bus.w_we)   n_we++;
        if (bus.pix_en) n_pix++;
        if (bus.busy)   n_busy++;
        if (bus.ack)    n_ack++;
        if (bus.b_we)   n_bwe++;
        if (bus.out_valid) begin
            n_ov++;
            if (!got_ov) begin
                got_ov = 1; fo_row = bus.out_row; fo_col = bus.out_col;
                fo_first = bus.out_first; fo_last = bus.out_last;
            end
        end
    end

    task automatic run_cfg(input int img, input int ic, input int oc, input int pulse_at, input int rst_at);
        int n;
        @(negedge clk);
        n_we = 0; n_pix = 0; n_ov = 0; n_busy = 0; n_ack = 0; n_bwe = 0; got_ov = 0;
        bus.req = 1; bus.img_size = LW'(img); bus.in_ch = LW'(ic); bus.out_ch = LW'(oc);
        @(posedge clk);
        build(img, ic, oc);
        @(negedge clk);
        bus.req = 0;
        bus.img_size = LW'($urandom_range(0, 1023));
        bus.in_ch    = LW'($urandom_range(0, 1023));
        bus.out_ch   = LW'($urandom_range(0, 1023));
        n = 0;
        while (q.size() > 0 && n < 20000) begin
            bus.req = (n == pulse_at);
            if (n == pulse_at) begin
                bus.img_size = LW'($urandom_range(5, 20));
                bus.in_ch    = LW'($urandom_range(1, 4));
                bus.out_ch   = LW'($urandom_range(1, 4));
            end
            if (n == rst_at) begin
                @(posedge clk);
                #1;
                xrst = 0;
                q.delete();
                #1;
                chk("reset_outputs_zero", int'(pack_act() == 53'd0), 1);
                @(negedge clk);
                xrst = 1;
                bus.req = 0;
                return;
            end
            @(negedge clk);
            n++;
        end
        bus.req = 0;
        chk("run_completes_in_budget", q.size(), 0);
        #1;
        chk("ack_pulses", n_ack, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int img, ic, oc;
        bus.req = 0; bus.img_size = '0; bus.in_ch = '0; bus.out_ch = '0;
        repeat (3) @(negedge clk);
        chk("reset_state_outputs", int'(pack_act() == 53'd0), 1);
        xrst = 1;
        repeat (2) @(negedge clk);

        // Smallest non-degenerate layer: exactly one output window
        run_cfg(5, 1, 1, -1, -1);
        chk("t1_w_we_count", n_we, 25);
        chk("t1_pix_en_count", n_pix, 25);
        chk("t1_out_valid_count", n_ov, 1);
        chk("t1_busy_cycles", n_busy, 56 + BIAS);
        chk("t1_b_we_count", n_bwe, BIAS);
        chk("t1_first_out_row", int'(fo_row), 0);
        chk("t1_first_out_col", int'(fo_col), 0);
        chk("t1_first_out_flags", int'({fo_first, fo_last}), 3);

        // Two by two channels with a req pulse mid-stream that must be ignored
        run_cfg(8, 2, 2, 60, -1);
        chk("t2_out_valid_count", n_ov, 64);
        chk("t2_w_we_count", n_we, 100);
        chk("t2_pix_en_count", n_pix, 256);
        chk("t2_busy_cycles", n_busy, 2 * (2 * (25 + 64) + 5) + 1 + 2 * BIAS);
        chk("t2_b_we_count", n_bwe, 2 * BIAS);

        // Degenerate sizes go straight to DONE
        run_cfg(4, 2, 2, -1, -1);
        chk("t3_busy_cycles", n_busy, 1);
        chk("t3_activity", n_we + n_pix + n_ov, 0);
        run_cfg(8, 1, 0, -1, -1);
        chk("t3b_busy_cycles", n_busy, 1);
        run_cfg(8, 0, 1, -1, -1);
        chk("t3c_busy_cycles", n_busy, 1);

        // Reset during STREAM with tags in flight, then a clean restart
        run_cfg(8, 1, 1, -1, 64);
        repeat (2) @(negedge clk);
        run_cfg(5, 1, 1, -1, -1);
        chk("t4_restart_out_valid_count", n_ov, 1);
        chk("t4_restart_w_we_count", n_we, 25);

        // Randomized layers, including occasional degenerate ones
        for (int r = 0; r < 8; r++) begin
            img = $urandom_range(3, 9);
            ic  = $urandom_range(0, 3);
            oc  = $urandom_range(0, 2);
            run_cfg(img, ic, oc, (r % 2 == 0) ? int'($urandom_range(1, 40)) : -1, -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
